// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter
// Shares one combinational 32-bit S-box word lookup between the key-expansion
// engine (key_*) and the encipher round datapath (data_*). Each lookup is a
// request/ack handshake: a granted word is substituted in the grant cycle,
// captured into that requester's result register, and acknowledged with a
// one-cycle pulse in the following cycle. key_lock gives the key engine
// exclusive use of the S-box during key expansion.

module aes_sbox_arbiter #(
  // 0: round-robin on ties, 1: key requester always wins ties
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        key_req,
  input  logic [31:0] key_word,
  output logic        key_ack,
  output logic [31:0] key_result,

  input  logic        data_req,
  input  logic [31:0] data_word,
  output logic        data_ack,
  output logic [31:0] data_result,

  input  logic        key_lock,

  output logic [31:0] sbox_in,
  input  logic [31:0] sbox_out,

  output logic        busy
);

  // Which requester was granted most recently; drives the round-robin tie-break.
  typedef enum logic {
    GRANT_KEY  = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  // Registered state
  logic        key_ack_q,     key_ack_d;
  logic        data_ack_q,    data_ack_d;
  logic [31:0] key_result_q,  key_result_d;
  logic [31:0] data_result_q, data_result_d;
  grant_e      last_grant_q,  last_grant_d;

  // Arbitration terms
  logic key_elig;
  logic data_elig;
  logic key_wins_tie;
  logic grant_key;
  logic grant_data;

  // A requester is ignored in its own ack cycle so the held req is not served twice.
  assign key_elig  = key_req  & ~key_ack_q;
  assign data_elig = data_req & ~data_ack_q & ~key_lock;

  // Tie-break policy is fixed at elaboration time.
  generate
    if (FIXED_PRIO != 0) begin : g_fixed_prio
      assign key_wins_tie = 1'b1;
    end else begin : g_round_robin
      // Key wins a tie only if data was the last one served.
      assign key_wins_tie = (last_grant_q == GRANT_DATA);
    end
  endgenerate

  // Same-cycle grant decision; at most one requester is granted.
  always_comb begin
    grant_key  = key_elig & (~data_elig | key_wins_tie);
    grant_data = data_elig & ~grant_key;
  end

  // Route the granted word to the shared S-box; with no grant the key word is
  // left on the bus so the S-box inputs do not toggle needlessly.
  assign sbox_in = grant_data ? data_word : key_word;

  // Next-state: capture the S-box result for the winner and schedule its ack.
  always_comb begin
    key_ack_d     = grant_key;
    data_ack_d    = grant_data;
    key_result_d  = key_result_q;
    data_result_d = data_result_q;
    last_grant_d  = last_grant_q;
    if (grant_key) begin
      key_result_d = sbox_out;
      last_grant_d = GRANT_KEY;
    end
    if (grant_data) begin
      data_result_d = sbox_out;
      last_grant_d  = GRANT_DATA;
    end
  end

  // State registers; reset discards any pending ack and restarts arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_ack_q     <= 1'b0;
      data_ack_q    <= 1'b0;
      key_result_q  <= 32'h0;
      data_result_q <= 32'h0;
      last_grant_q  <= GRANT_DATA;
    end else begin
      key_ack_q     <= key_ack_d;
      data_ack_q    <= data_ack_d;
      key_result_q  <= key_result_d;
      data_result_q <= data_result_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign key_ack     = key_ack_q;
  assign data_ack    = data_ack_q;
  assign key_result  = key_result_q;
  assign data_result = data_result_q;

  // Busy whenever a grant can be issued this cycle or an ack is outstanding.
  assign busy = key_elig | data_elig | key_ack_q | data_ack_q;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Testbench for aes_sbox_arbiter. Two instances (round-robin and fixed
// priority) share the same requester stimulus; each has its own S-box model
// computed from GF(2^8) arithmetic. A reference model derived from the
// arbitration rules predicts acks, results, busy and sbox_in every cycle.

module tb_aes_sbox_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_req, data_req, key_lock;
  logic [31:0] key_word, data_word;

  logic [1:0]  key_ack, data_ack, busy;
  logic [31:0] key_result [2];
  logic [31:0] data_result [2];
  logic [31:0] sbox_in [2];
  logic [31:0] sbox_out [2];

  int nchecks = 0;
  int nerr    = 0;

  // Reference model state per instance (0 = round-robin, 1 = fixed priority)
  bit          m_kack [2];
  bit          m_dack [2];
  logic [31:0] m_kres [2];
  logic [31:0] m_dres [2];
  bit          m_last_data [2];

  always #5 clk = ~clk;

  // ---------------- AES S-box from field arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    int e;
    r = 8'h01;
    base = a;
    e = 254;
    while (e != 0) begin
      if ((e & 1) != 0) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return r;  // 0 maps to 0 since 0^254 = 0
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sbox_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  assign sbox_out[0] = sbox_word(sbox_in[0]);
  assign sbox_out[1] = sbox_word(sbox_in[1]);

  // ---------------- DUTs ----------------
  aes_sbox_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .key_req(key_req), .key_word(key_word), .key_ack(key_ack[0]), .key_result(key_result[0]),
    .data_req(data_req), .data_word(data_word), .data_ack(data_ack[0]), .data_result(data_result[0]),
    .key_lock(key_lock), .sbox_in(sbox_in[0]), .sbox_out(sbox_out[0]), .busy(busy[0])
  );

  aes_sbox_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .key_req(key_req), .key_word(key_word), .key_ack(key_ack[1]), .key_result(key_result[1]),
    .data_req(data_req), .data_word(data_word), .data_ack(data_ack[1]), .data_result(data_result[1]),
    .key_lock(key_lock), .sbox_in(sbox_in[1]), .sbox_out(sbox_out[1]), .busy(busy[1])
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kack[i]      = 1'b0;
      m_dack[i]      = 1'b0;
      m_kres[i]      = 32'h0;
      m_dres[i]      = 32'h0;
      m_last_data[i] = 1'b1;
    end
  endtask

  // One clock cycle: check combinational outputs before the edge, advance
  // the model at the edge, then check registered outputs just after it.
  // Called with inputs already driven for this cycle (posedge + 1).
  task automatic step();
    bit   gk [2];
    bit   gd [2];
    logic ke, de;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ke = key_req && !m_kack[i];
      de = data_req && !m_dack[i] && !key_lock;
      if (ke && de) begin
        gk[i] = (i == 1) || m_last_data[i];
        gd[i] = !gk[i];
      end else begin
        gk[i] = ke;
        gd[i] = de;
      end
      chk($sformatf("busy%0d", i), {31'h0, busy[i]},
          {31'h0, (ke || de || m_kack[i] || m_dack[i])});
      chk($sformatf("sbox_in%0d", i), sbox_in[i], gd[i] ? data_word : key_word);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_kack[i] = gk[i];
      m_dack[i] = gd[i];
      if (gk[i]) m_kres[i] = sbox_word(key_word);
      if (gd[i]) m_dres[i] = sbox_word(data_word);
      if (gk[i] || gd[i]) m_last_data[i] = gd[i];
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("key_ack%0d", i),     {31'h0, key_ack[i]},  {31'h0, m_kack[i]});
      chk($sformatf("data_ack%0d", i),    {31'h0, data_ack[i]}, {31'h0, m_dack[i]});
      chk($sformatf("key_result%0d", i),  key_result[i],  m_kres[i]);
      chk($sformatf("data_result%0d", i), data_result[i], m_dres[i]);
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_key_ack%0d", i),     {31'h0, key_ack[i]},  32'h0);
      chk($sformatf("rst_data_ack%0d", i),    {31'h0, data_ack[i]}, 32'h0);
      chk($sformatf("rst_key_result%0d", i),  key_result[i],  32'h0);
      chk($sformatf("rst_data_result%0d", i), data_result[i], 32'h0);
    end
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    key_req   = 1'b0;
    data_req  = 1'b0;
    key_lock  = 1'b0;
    key_word  = 32'h0;
    data_word = 32'h0;
    model_reset();

    // Sanity of the reference S-box against known table entries
    chk("sbox_ref_00", {24'h0, sbox_byte(8'h00)}, 32'h63);
    chk("sbox_ref_53", {24'h0, sbox_byte(8'h53)}, 32'hed);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("por_key_ack%0d", i),     {31'h0, key_ack[i]},  32'h0);
      chk($sformatf("por_data_ack%0d", i),    {31'h0, data_ack[i]}, 32'h0);
      chk($sformatf("por_key_result%0d", i),  key_result[i],  32'h0);
      chk($sformatf("por_data_result%0d", i), data_result[i], 32'h0);
      chk($sformatf("por_busy%0d", i),        {31'h0, busy[i]}, 32'h0);
    end
    #2;
    reset_n = 1'b1;

    // Key only, word 0: ack one cycle later with 0x63636363, no data ack
    key_req  = 1'b1;
    key_word = 32'h00000000;
    step();
    chk("t1_key_ack",    {31'h0, key_ack[0]}, 32'h1);
    chk("t1_key_result", key_result[0], 32'h63636363);
    key_req = 1'b0;
    step();
    chk("t1_data_ack", {31'h0, data_ack[0]}, 32'h0);

    // Data only, held: acks at N+1 and N+3
    data_req  = 1'b1;
    data_word = 32'h01020304;
    step();
    chk("t2_data_ack1",    {31'h0, data_ack[0]}, 32'h1);
    chk("t2_data_result",  data_result[0], 32'h7c777bf2);
    step();
    chk("t2_data_ack2",    {31'h0, data_ack[0]}, 32'h0);
    step();
    chk("t2_data_ack3",    {31'h0, data_ack[0]}, 32'h1);
    data_req = 1'b0;
    step();

    // Both requesting continuously from reset: K,D,K,D on both policies
    reset_pulse();
    key_req   = 1'b1;
    key_word  = 32'h53535353;
    data_req  = 1'b1;
    data_word = 32'h00000000;
    step();
    chk("t3_first_key", {31'h0, key_ack[0]},  32'h1);
    chk("t3_fp_first",  {31'h0, key_ack[1]},  32'h1);
    step();
    chk("t3_then_data", {31'h0, data_ack[0]}, 32'h1);
    repeat (4) step();
    chk("t3_key_result",  key_result[0],  32'hedededed);
    chk("t3_data_result", data_result[0], 32'h63636363);
    key_req  = 1'b0;
    data_req = 1'b0;
    step();

    // Tie after a key grant: round-robin serves data, fixed priority serves key
    key_req  = 1'b1;
    key_word = 32'h11223344;
    step();
    key_req = 1'b0;
    step();
    key_req   = 1'b1;
    data_req  = 1'b1;
    key_word  = 32'h55667788;
    data_word = 32'h99aabbcc;
    step();
    chk("t4_rr_data", {31'h0, data_ack[0]}, 32'h1);
    chk("t4_fp_key",  {31'h0, key_ack[1]},  32'h1);
    step();
    chk("t4_rr_key",  {31'h0, key_ack[0]},  32'h1);
    chk("t4_fp_data", {31'h0, data_ack[1]}, 32'h1);
    key_req  = 1'b0;
    data_req = 1'b0;
    step();

    // key_lock blocks data for 10 cycles, then data served one cycle after release
    key_lock  = 1'b1;
    data_req  = 1'b1;
    data_word = 32'haabbccdd;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("t5_locked", {31'h0, data_ack[0]}, 32'h0);
    end
    key_lock = 1'b0;
    step();
    chk("t5_unlock_ack",    {31'h0, data_ack[0]}, 32'h1);
    chk("t5_unlock_result", data_result[0], 32'hacea4bc1);
    data_req = 1'b0;
    step();

    // Reset right after a grant: everything clears, key served first afterwards
    key_req  = 1'b1;
    key_word = 32'h01010101;
    step();
    reset_pulse();
    data_req  = 1'b1;
    data_word = 32'h02020202;
    key_word  = 32'h03030303;
    step();
    chk("t6_key_first",  {31'h0, key_ack[0]}, 32'h1);
    chk("t6_key_result", key_result[0], 32'h7b7b7b7b);
    step();
    key_req  = 1'b0;
    data_req = 1'b0;
    step();

    // Randomised traffic with requests held until acked, occasional withdrawals
    for (int n = 0; n < 400; n++) begin
      if (key_req && !(m_kack[0] || m_kack[1]) && $urandom_range(15) != 0) begin
        key_req = 1'b1;
      end else begin
        key_req  = ($urandom_range(2) != 0);
        key_word = $urandom;
      end
      if (data_req && !(m_dack[0] || m_dack[1]) && $urandom_range(15) != 0) begin
        data_req = 1'b1;
      end else begin
        data_req  = ($urandom_range(2) != 0);
        data_word = $urandom;
      end
      if ($urandom_range(7) == 0) key_lock = ~key_lock;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/aes_sbox_arbiter.md
Name: aes_sbox_arbiter

Overview:
- Shares one combinational 32-bit S-box word lookup (four parallel aes_sbox byte lookups) between two requesters.
- Requester 0 is the key-expansion engine (aes_key_mem sboxw/new_sboxw). Requester 1 is the encipher round datapath.
- Arbitrates on request/ack handshakes and registers the looked-up word. Requester 0 can be given exclusive use during key expansion.
- Sits in the AES core between both engines and the single S-box instance.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = key requester always wins ties.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- key_req  input  1  key-expansion lookup request; held until key_ack
- key_word  input  32  word to substitute; stable while key_req is high
- key_ack  output  1  one-cycle pulse; key_result valid this cycle
- key_result  output  32  substituted word for key requester
- data_req  input  1  datapath lookup request; held until data_ack
- data_word  input  32  word to substitute; stable while data_req is high
- data_ack  output  1  one-cycle pulse; data_result valid this cycle
- data_result  output  32  substituted word for datapath requester
- key_lock  input  1  while high, data requests are never granted
- sbox_in  output  32  word driven to the shared S-box
- sbox_out  input  32  combinational S-box result for sbox_in
- busy  output  1  high in any cycle a grant is issued or an ack is pending

Behaviour:
- Reset is asynchronous, active-low: reset_n, asynchronous, active-low; clock clk.
- Reset values: key_ack=0, data_ack=0, key_result=0, data_result=0, busy=0, last_grant=DATA, internal pending flags=0.
- Eligibility:
  - key eligible = key_req & ~key_ack.
  - data eligible = data_req & ~data_ack & ~key_lock.
  - A requester's req is ignored in its own ack cycle, which prevents double service.
- Grant (combinational, same cycle):
  - Only one eligible requester: it is granted.
  - Both eligible, FIXED_PRIO=1: key is granted.
  - Both eligible, FIXED_PRIO=0: the requester not equal to last_grant is granted.
  - Neither eligible: no grant.
- sbox_in:
  - Equals the granted requester's word.
  - With no grant, it holds the key_word value, purely to avoid toggling; it has no functional meaning then.
- On the clk edge with a grant:
  - The granted result register loads sbox_out.
  - The matching ack goes high for exactly the next cycle.
  - last_grant updates to the granted requester.
- Latency: request seen in cycle N -> ack and result in cycle N+1 when uncontended. Results hold their value after ack until the next grant to the same requester.
- Throughput: one lookup per cycle overall. A single requester gets at most one lookup per 2 cycles. Two requesters interleave at full rate.
- key_lock:
  - Rising while a data grant is in flight (ack due next cycle) does not cancel it; that ack still completes.
  - Blocks only new data grants.
- Requester drops req before grant: the request is withdrawn, with no ack and no state change.
- Simultaneous ack and new grant in the same cycle are allowed, provided they go to different requesters.
- busy = any eligible request | key_ack | data_ack.
- Reset mid-operation: pending acks are discarded and arbitration restarts from reset state.
- No other state: no FIFO, no queue depth beyond one in-flight lookup per requester.

Test Plan:
- Key only, key_word=0x00000000, sbox model attached -> key_ack high exactly one cycle later, key_result=0x63636363, data_ack stays 0.
- Data only, data_word=0x01020304 -> data_ack at N+1, data_result=0x7c777bf2. Holding data_req gives the next ack at N+3.
- FIXED_PRIO=0, both requesting continuously from reset, key_word=0x53535353, data_word=0x00000000 -> grants alternate K,D,K,D. Acks on consecutive cycles. key_result=0xedededed, data_result=0x63636363.
- FIXED_PRIO=1, both requesting in the same cycle -> key acked first, data acked the cycle after. The second key lookup is granted only after data, because key is ineligible in its ack cycle.
- key_lock=1 with data_req held 10 cycles and key idle -> no data_ack. Drop key_lock -> data_ack 1 cycle later with the correct result.
- Assert reset_n low in the cycle after a grant -> key_ack/data_ack/results read 0 immediately. After release, a new key request is serviced first.
